// File: rtl/boolean_lut_engine.sv
// boolean_lut_engine: programmable truth-table evaluator with serial table
// load and an optional self-check sweep (enabled by defining BOOL_LUT_SWEEP_EN).
// Reset loads y = a'bd' + bc + bd' (0xD0D0) when IN_WIDTH == 4.
module boolean_lut_engine #(
  parameter int IN_WIDTH = 4,
  parameter int CHANNELS = 2
) (
  input  logic                           clkWire,
  input  logic                           rstWire,
  input  logic                           inValidWire,
  input  logic [CHANNELS*IN_WIDTH-1:0]   inWire,
  output logic                           outValidWire,
  output logic [CHANNELS-1:0]            outWire,
  input  logic                           loadValidWire,
  input  logic                           loadBitWire,
  output logic                           loadReadyWire,
  input  logic                           sweepStartWire,
  output logic                           sweepBusyWire,
  output logic                           sweepDoneWire,
  output logic [(1<<IN_WIDTH)-1:0]       sweepMapWire,
  output logic [IN_WIDTH:0]              mintermCountWire
);

  localparam int DEPTH = 1 << IN_WIDTH;
  localparam logic [63:0] RESET_WIDE = (IN_WIDTH == 4) ? 64'h0000_0000_0000_D0D0 : 64'd0;
  localparam logic [DEPTH-1:0] RESET_TABLE = RESET_WIDE[DEPTH-1:0];

`ifdef BOOL_LUT_SWEEP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SWEEP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1} state_t;
`endif

  state_t state_reg, state_next;

  logic [DEPTH-1:0]    table_reg;
  logic [DEPTH-1:0]    shadow_reg;
  logic [DEPTH-1:0]    shadow_next;
  logic [IN_WIDTH-1:0] load_cnt_reg;
  logic                load_ready;
  logic                load_accept;
  logic                load_last;

  logic                out_valid_reg;
  logic [CHANNELS-1:0] out_reg;
  logic [CHANNELS-1:0] eval_next;

  // A bit is only taken while no sweep is reading the table.
  assign load_ready  = (state_reg == IDLE) || (state_reg == LOAD);
  assign load_accept = loadValidWire & load_ready;
  assign load_last   = &load_cnt_reg;
  assign shadow_next = {loadBitWire, shadow_reg[DEPTH-1:1]};

  assign loadReadyWire = load_ready;
  assign outValidWire  = out_valid_reg;
  assign outWire       = out_reg;

  // Each channel indexes the active table independently.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_eval
      assign eval_next[gi] = table_reg[inWire[gi*IN_WIDTH +: IN_WIDTH]];
    end
  endgenerate

`ifdef BOOL_LUT_SWEEP_EN
  logic [IN_WIDTH-1:0] idx_reg;
  logic [DEPTH-1:0]    map_acc_reg, map_next, map_out_reg;
  logic [IN_WIDTH:0]   cnt_acc_reg, cnt_next, cnt_out_reg;
  logic                done_reg;
  logic                sweep_bit;
  logic                sweep_last;
  logic                start_go;

  assign sweep_bit  = table_reg[idx_reg];
  assign sweep_last = &idx_reg;
  // A simultaneous load bit takes priority over the start request.
  assign start_go   = (state_reg == IDLE) && sweepStartWire && !load_accept;

  // Accumulate the current entry into the in-flight map and minterm count.
  always_comb begin
    map_next          = map_acc_reg;
    map_next[idx_reg] = sweep_bit;
    cnt_next          = cnt_acc_reg + (IN_WIDTH+1)'(sweep_bit);
  end

  // Sweep datapath: step the index, publish map/count only at the final entry.
  always_ff @(posedge clkWire) begin
    if (rstWire) begin
      idx_reg     <= '0;
      map_acc_reg <= '0;
      cnt_acc_reg <= '0;
      map_out_reg <= '0;
      cnt_out_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start_go) begin
        idx_reg     <= '0;
        map_acc_reg <= '0;
        cnt_acc_reg <= '0;
      end else if (state_reg == SWEEP) begin
        idx_reg     <= idx_reg + IN_WIDTH'(1);
        map_acc_reg <= map_next;
        cnt_acc_reg <= cnt_next;
        if (sweep_last) begin
          map_out_reg <= map_next;
          cnt_out_reg <= cnt_next;
          done_reg    <= 1'b1;
        end
      end
    end
  end

  assign sweepBusyWire    = (state_reg == SWEEP);
  assign sweepDoneWire    = done_reg;
  assign sweepMapWire     = map_out_reg;
  assign mintermCountWire = cnt_out_reg;
`else
  logic unused_sweep_start;
  assign unused_sweep_start = sweepStartWire;

  assign sweepBusyWire    = 1'b0;
  assign sweepDoneWire    = 1'b0;
  assign sweepMapWire     = '0;
  assign mintermCountWire = '0;
`endif

  // State register.
  always_ff @(posedge clkWire) begin
    if (rstWire) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: loads run to completion, sweeps run one table pass.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load_accept) begin
          state_next = LOAD;
`ifdef BOOL_LUT_SWEEP_EN
        end else if (sweepStartWire) begin
          state_next = SWEEP;
`endif
        end
      end
      LOAD: begin
        if (load_accept && load_last) begin
          state_next = IDLE;
        end
      end
`ifdef BOOL_LUT_SWEEP_EN
      SWEEP: begin
        if (sweep_last) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Shadow load: shift in accepted bits, commit the full table atomically.
  always_ff @(posedge clkWire) begin
    if (rstWire) begin
      shadow_reg   <= '0;
      load_cnt_reg <= '0;
      table_reg    <= RESET_TABLE;
    end else if (load_accept) begin
      shadow_reg <= shadow_next;
      if (load_last) begin
        table_reg    <= shadow_next;
        load_cnt_reg <= '0;
      end else begin
        load_cnt_reg <= load_cnt_reg + IN_WIDTH'(1);
      end
    end
  end

  // Registered evaluation; the output holds when no valid input is offered.
  always_ff @(posedge clkWire) begin
    if (rstWire) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      out_valid_reg <= inValidWire;
      if (inValidWire) begin
        out_reg <= eval_next;
      end
    end
  end

endmodule

// File: tb/tb_boolean_lut_engine.sv
// Self-checking bench for boolean_lut_engine (IN_WIDTH=4, CHANNELS=2).
// Sweep expectations follow BOOL_LUT_SWEEP_EN as seen by this compilation.
module tb_boolean_lut_engine;

  localparam int IW    = 4;
  localparam int CH    = 2;
  localparam int DEPTH = 16;
`ifdef BOOL_LUT_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [7:0]  din;
  logic        ov;
  logic [1:0]  dout;
  logic        lv, lb, lr, st;
  logic        busy, done;
  logic [15:0] map;
  logic [4:0]  cnt;

  always #5 clk = ~clk;

  boolean_lut_engine #(.IN_WIDTH(IW), .CHANNELS(CH)) dut (
    .clkWire(clk), .rstWire(rst),
    .inValidWire(iv), .inWire(din),
    .outValidWire(ov), .outWire(dout),
    .loadValidWire(lv), .loadBitWire(lb), .loadReadyWire(lr),
    .sweepStartWire(st), .sweepBusyWire(busy), .sweepDoneWire(done),
    .sweepMapWire(map), .mintermCountWire(cnt)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: truth table as a bit array, pending load bits as a queue,
  // and the number of sweep cycles still to run.
  bit          tbl [DEPTH];
  bit          pend [$];
  int          sw_rem;
  logic [1:0]  exp_out;
  logic        exp_ov;
  logic [15:0] exp_map;
  logic [4:0]  exp_cnt;

  typedef struct {
    logic [3:0] in0;
    logic       exp0;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    logic [3:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = 4'(i);
      // y = a'bd' + bc + bd' with a = v[3] ... d = v[0]
      tbl[i] = (!v[3] && v[2] && !v[0]) || (v[2] && v[1]) || (v[2] && !v[0]);
    end
    pend.delete();
    sw_rem  = 0;
    exp_out = 2'b00;
    exp_ov  = 1'b0;
    exp_map = 16'h0;
    exp_cnt = 5'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; iv = 1'b0; din = 8'h00; lv = 1'b0; lb = 1'b0; st = 1'b0;
    @(posedge clk); #1;
    model_reset();
    txn++;
    $display("txn %0d: reset", txn);
    chk("rst_out_valid", 32'(ov), 32'(0));
    chk("rst_out", 32'(dout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_map", 32'(map), 32'(0));
    chk("rst_count", 32'(cnt), 32'(0));
    chk("rst_load_ready", 32'(lr), 32'(1));
    rst = 1'b0;
  endtask

  // One clock of stimulus; the model predicts every output after the edge.
  task automatic cycle(input bit i_v, input logic [7:0] i_d, input bit l_v, input bit l_b, input bit s_t);
    bit rdy_exp, acc, start_ok, done_exp;
    int n;
    iv = i_v; din = i_d; lv = l_v; lb = l_b; st = s_t;
    rdy_exp = (sw_rem == 0);
    chk("load_ready", 32'(lr), 32'(rdy_exp));
    acc      = l_v && rdy_exp;
    start_ok = SWEEP_EN && s_t && (sw_rem == 0) && (pend.size() == 0) && !acc;
    if (i_v) begin
      for (int c = 0; c < CH; c++) exp_out[c] = tbl[i_d[c*IW +: IW]];
    end
    exp_ov   = i_v;
    done_exp = 1'b0;
    if (sw_rem > 0) begin
      sw_rem--;
      if (sw_rem == 0) begin
        done_exp = 1'b1;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
          exp_map[i] = tbl[i];
          n += int'(tbl[i]);
        end
        exp_cnt = 5'(n);
      end
    end
    if (start_ok) sw_rem = DEPTH;
    if (acc) begin
      pend.push_back(l_b);
      if (pend.size() == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) tbl[i] = pend[i];
        pend.delete();
      end
    end
    @(posedge clk); #1;
    txn++;
    $display("txn %0d: iv=%0b in=%02h lv=%0b lb=%0b st=%0b -> out=%02b ov=%0b busy=%0b done=%0b map=%04h cnt=%0d",
             txn, i_v, i_d, l_v, l_b, s_t, dout, ov, busy, done, map, cnt);
    chk("out_valid", 32'(ov), 32'(exp_ov));
    chk("out", 32'(dout), 32'(exp_out));
    chk("busy", 32'(busy), 32'(sw_rem > 0));
    chk("done", 32'(done), 32'(done_exp));
    chk("map", 32'(map), 32'(exp_map));
    chk("count", 32'(cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [15:0] w;

    vecs[0]  = '{4'h0, 1'b0}; vecs[1]  = '{4'h1, 1'b0};
    vecs[2]  = '{4'h2, 1'b0}; vecs[3]  = '{4'h3, 1'b0};
    vecs[4]  = '{4'h4, 1'b1}; vecs[5]  = '{4'h5, 1'b0};
    vecs[6]  = '{4'h6, 1'b1}; vecs[7]  = '{4'h7, 1'b1};
    vecs[8]  = '{4'h8, 1'b0}; vecs[9]  = '{4'h9, 1'b0};
    vecs[10] = '{4'hA, 1'b0}; vecs[11] = '{4'hB, 1'b0};
    vecs[12] = '{4'hC, 1'b1}; vecs[13] = '{4'hD, 1'b0};
    vecs[14] = '{4'hE, 1'b1}; vecs[15] = '{4'hF, 1'b1};

    // Reset-time function on channel 0.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, {4'h0, vecs[k].in0}, 1'b0, 1'b0, 1'b0);
      chk("vec_out0", 32'(dout[0]), 32'(vecs[k].exp0));
    end
    // Output holds while inValid is low.
    cycle(1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
    chk("hold_out0", 32'(dout[0]), 32'(1));

    // Sweep of the reset table.
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef BOOL_LUT_SWEEP_EN
    chk("sweep_rst_map", 32'(map), 32'(16'hD0D0));
    chk("sweep_rst_count", 32'(cnt), 32'(6));
`else
    chk("sweep_off_map", 32'(map), 32'(0));
`endif

    // Load 0x8000 with gaps; evaluation stays on the old table until commit.
    w = 16'h8000;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 2) begin
        cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        chk("gap_old_tbl", 32'(dout[0]), 32'(1));
      end
      cycle(1'b1, 8'h04, 1'b1, w[i], 1'b0);
      chk("preload_old_tbl", 32'(dout[0]), 32'(1));
    end
    cycle(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("commit_F", 32'(dout[0]), 32'(1));
    cycle(1'b1, 8'h0E, 1'b0, 1'b0, 1'b0);
    chk("commit_E", 32'(dout[0]), 32'(0));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef BOOL_LUT_SWEEP_EN
    chk("sweep_8000_map", 32'(map), 32'(16'h8000));
    chk("sweep_8000_count", 32'(cnt), 32'(1));

    // Loads are refused during a sweep; start is ignored mid-load.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("sweep_ready_low", 32'(lr), 32'(0));
    end
    for (int k = 0; k < 11; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("tbl_kept_F", 32'(dout[0]), 32'(1));
    cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    chk("tbl_kept_4", 32'(dout[0]), 32'(0));
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("start_in_load", 32'(busy), 32'(0));
`endif

    // Two channels around the commit of 0x0020.
    do_reset();
    w = 16'h0020;
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, w[i], 1'b0);
    cycle(1'b1, 8'h54, 1'b1, w[15], 1'b0);
    chk("two_ch_old", 32'(dout), 32'(2'b01));
    cycle(1'b1, 8'h54, 1'b0, 1'b0, 1'b0);
    chk("two_ch_new", 32'(dout), 32'(2'b10));

    // Reset mid-load discards the partial shadow.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("partial_no_commit", 32'(dout[0]), 32'(0));
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("full_commit", 32'(dout[0]), 32'(1));

    // Reset mid-sweep aborts with no done pulse.
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 14; k++) begin
      cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      chk("abort_no_done", 32'(done), 32'(0));
    end
    chk("abort_tbl", 32'(dout), 32'(2'b11));

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 80) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 12) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
